// File: rtl/capture_frame_sched.sv
// capture_frame_sched: ping-pong frame-buffer scheduler between camera capture and CNN consumer
module capture_frame_sched #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              cap_en,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [3:0]        cap_dout,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [3:0]        fb_dout,
  output logic              frame_valid,
  output logic              rd_buf,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;
  localparam logic [ADDR_W:0] FP = (ADDR_W+1)'(FRAME_PIXELS);
  state_t state;
  logic vsync_q, wr_buf, oldest, overrun;
  logic [1:0] full, full_nx;
  logic [ADDR_W:0] pix_cnt;
  logic sof, eof, ack, room, commit;
  assign sof = vsync_q & ~vsync;
  assign eof = ~vsync_q & vsync;
  assign ack = frame_ack & frame_valid;
  assign room = pix_cnt < FP;
  assign commit = state == CAPTURE && eof && pix_cnt == FP && !overrun;
  assign frame_valid = |full;
  assign rd_buf = oldest;
  // ack and commit always hit different buffers, so both may apply together
  always_comb begin
    full_nx = full;
    if (ack) full_nx[oldest] = 1'b0;
    if (commit) full_nx[wr_buf] = 1'b1;
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vsync_q <= 1'b0;
      wr_buf <= 1'b0;
      oldest <= 1'b0;
      overrun <= 1'b0;
      full <= 2'b00;
      pix_cnt <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_dout <= '0;
      frame_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      fb_we <= state == CAPTURE && cap_we && room;
      fb_addr <= {wr_buf, cap_addr};
      fb_dout <= cap_dout;
      frame_err <= state == CAPTURE && eof && !commit;
      full <= full_nx;
      oldest <= ack ? ~oldest : (commit && !full[~wr_buf]) ? wr_buf : oldest;
      case (state)
        IDLE: if (sof && cap_en) begin
          if (!(&full)) begin
            wr_buf <= full[0];
            pix_cnt <= '0;
            overrun <= 1'b0;
            state <= CAPTURE;
          end else begin
            drop_cnt <= drop_cnt + {7'd0, ~&drop_cnt};
            state <= SKIP;
          end
        end
        CAPTURE: if (eof) state <= IDLE;
          else if (cap_we) begin
            if (room) pix_cnt <= pix_cnt + 1'b1;
            else overrun <= 1'b1;
          end
        default: if (eof) state <= IDLE;
      endcase
    end
endmodule

// File: doc/capture_frame_sched.md
# capture_frame_sched

Ping-pong frame-buffer scheduler between the OV7670 capture datapath and the CNN frame consumer, in the pclk domain. It arbitrates two frame buffers, steers each captured frame's write strobes into a free buffer, and validates frame length. It hands completed frames to the consumer with a valid/ack handshake, oldest first. When both buffers are held, it drops incoming frames and counts them.

## Interface
- FRAME_PIXELS, 307200, exact number of cap_we strobes in a good frame
- ADDR_W, 19, width of capture address
- pclk  in  1  pixel clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- vsync  in  1  camera vsync; high = vertical blanking
- cap_en  in  1  capture enable; sampled only at frame start
- cap_we  in  1  pixel write strobe from capture datapath
- cap_addr  in  ADDR_W  pixel address from capture datapath
- cap_dout  in  4  pixel data from capture datapath
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  ADDR_W+1  {wr_buf, cap_addr}
- fb_dout  out  4  pixel data to frame buffer
- frame_valid  out  1  a completed frame is offered to the consumer
- rd_buf  out  1  buffer index offered; stable while frame_valid is high
- frame_ack  in  1  consumer releases rd_buf; honoured only while frame_valid is high
- frame_err  out  1  one-cycle pulse: short or overrun frame discarded
- drop_cnt  out  8  frames dropped for lack of a free buffer; saturates at 255

## Operation
- Edge detect: vsync_q is a register of vsync, reset value 0.
  - sof = vsync_q & ~vsync.
  - eof = ~vsync_q & vsync.
- Buffer state: full[1:0] and oldest (index of the earlier-committed full buffer). Free buffer = lowest index with full == 0.
- FSM states: IDLE, CAPTURE, SKIP.
  - IDLE, sof, cap_en=1, a free buffer exists: wr_buf <= free index, pix_cnt <= 0, go to CAPTURE.
  - IDLE, sof, cap_en=1, no free buffer: drop_cnt++ (saturating), go to SKIP.
  - IDLE, sof, cap_en=0: stay in IDLE.
  - IDLE, eof: ignored.
  - CAPTURE, each cap_we while pix_cnt < FRAME_PIXELS: fb_we=1, pix_cnt++.
  - CAPTURE, cap_we while pix_cnt == FRAME_PIXELS: write suppressed, overrun flag set.
  - CAPTURE, eof with pix_cnt == FRAME_PIXELS and no overrun: full[wr_buf] <= 1. If the other buffer is empty, oldest <= wr_buf. Go to IDLE.
  - CAPTURE, eof otherwise: frame_err pulse, buffer stays free, go to IDLE.
  - SKIP: fb_we=0 throughout; eof returns to IDLE.
- cap_en deasserted mid-frame does not abort the frame in progress.
- Consumer handshake:
  - frame_valid = |full; rd_buf = oldest.
  - frame_ack & frame_valid: full[rd_buf] <= 0, oldest <= ~rd_buf.
  - The other buffer, if full, is offered on the next cycle.
- Simultaneous commit and ack in one cycle: both apply. They always target different buffers. oldest becomes the committed buffer.
- pix_cnt is ADDR_W+1 bits wide. No wrap: it saturates at FRAME_PIXELS. The addressing source is cap_addr; pix_cnt is used only for validation.
- Reset values: all outputs 0; state IDLE; full=00; oldest=0; pix_cnt=0; wr_buf=0.
- Reset mid-frame discards the frame. After release, the block waits for the next sof. A frame already in progress at release is never partially written.

## Timing
- Datapath latency 1 cycle: fb_we, fb_addr and fb_dout are registered copies of cap_we (gated), {wr_buf, cap_addr} and cap_dout.
- sof/eof act on the cycle after the vsync edge.
- The first write accepted is the first cap_we sampled in CAPTURE.
- Commit on eof sets frame_valid on the following cycle.
- frame_err is high for exactly one cycle, the cycle after the eof-detect cycle.
- Ack to next offer: 1 cycle. frame_valid may stay high continuously if both buffers are full.
- drop_cnt updates the cycle after sof.

## Test plan
- FRAME_PIXELS=16, cap_en=1, one frame of 16 strobes at cap_addr 0..15 -> fb_addr 0x00000..0x0000F. One cycle after eof: frame_valid=1, rd_buf=0.
- Two good frames with no ack -> rd_buf=0 and full=11. Third frame -> drop_cnt=1, no fb_we. Ack -> rd_buf=1 next cycle. Ack -> frame_valid=0.
- Frame with 15 strobes -> frame_err single pulse, frame_valid stays 0, next frame writes buffer 0. Frame with 17 strobes -> 16 fb_we pulses then frame_err.
- Commit of buffer 1 coincident with frame_ack of buffer 0 -> full=10, rd_buf=1, frame_valid stays 1.
- cap_en=0 at sof, toggled to 1 mid-frame -> no fb_we for that frame, capture starts next sof. rst_n pulsed mid-CAPTURE -> outputs 0 immediately, no commit, resume at next sof.
- 260 frames with both buffers held -> drop_cnt saturates at 255.
